// File: rtl/eq_pkg.sv
// -----------------------------------------------------------------------------
// eq_pkg
// Shared constants for the 1-bit equality comparator and its statistics logic.
//   CNT_W_DEF   : default width of the match/miss counters
//   CNT_MAX_DEF : saturation value for a counter of default width
//   sat_max()   : all-ones value for an arbitrary counter width
// -----------------------------------------------------------------------------
package eq_pkg;

    localparam int unsigned CNT_W_DEF = 8;

    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    localparam logic [63:0] CNT_MAX_DEF = sat_max(CNT_W_DEF);

endpackage

// File: rtl/eq_cell.sv
// -----------------------------------------------------------------------------
// eq_cell
// Purely combinational 1-bit equality cell.
//   x, y : compared bits (inputs)
//   s1   : both-one term  (x & y)
//   s2   : both-zero term (~x & ~y)
//   s    : equality, s1 | s2
// X/Z on the inputs propagates naturally through the gate expressions.
// -----------------------------------------------------------------------------
module eq_cell (
    input  logic x,
    input  logic y,
    output logic s1,
    output logic s2,
    output logic s
);

    assign s1 = x & y;
    assign s2 = ~x & ~y;
    assign s  = s1 | s2;

endmodule

// File: rtl/eq.sv
// -----------------------------------------------------------------------------
// eq
// 1-bit equality comparator with registered statistics.
//   s         : combinational equality of x and y (output)
//   x, y      : compared bits (inputs)
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   clr       : synchronous clear of counters and edge flags (active-high)
//   s_q       : s registered on clk
//   match_cnt : saturating count of cycles with s_q = 1
//   miss_cnt  : saturating count of cycles with s_q = 0
//   rise      : one-cycle pulse, the cycle after s_q goes 0->1
//   fall      : one-cycle pulse, the cycle after s_q goes 1->0
// -----------------------------------------------------------------------------
module eq
    import eq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    output logic             s,
    input  logic             x,
    input  logic             y,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic             s_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             rise,
    output logic             fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic s1;
    logic s2;
    logic w_s;

    logic             r_s_q;
    logic             r_s_q_d;
    logic             r_loaded;   // r_s_q holds a value sampled from s
    logic             r_hist_ok;  // r_s_q_d holds a value sampled from s
    logic [CNT_W-1:0] r_match_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             r_rise;
    logic             r_fall;

    eq_cell u_cell (
        .x  (x),
        .y  (y),
        .s1 (s1),
        .s2 (s2),
        .s  (w_s)
    );

    assign s = w_s;

    // Edge flags compare the two most recent sampled values of s. The reset
    // value of s_q is not a sample, so the first load after reset can never
    // produce a pulse; r_hist_ok gates the detector until both history
    // registers hold real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q       <= 1'b0;
            r_s_q_d     <= 1'b0;
            r_loaded    <= 1'b0;
            r_hist_ok   <= 1'b0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
        end else begin
            r_s_q     <= w_s;
            r_s_q_d   <= r_s_q;
            r_loaded  <= 1'b1;
            r_hist_ok <= r_loaded;

            if (clr) begin
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
                r_rise      <= 1'b0;
                r_fall      <= 1'b0;
            end else begin
                if (r_s_q) begin
                    if (r_match_cnt != CNT_MAX)
                        r_match_cnt <= r_match_cnt + CNT_W'(1);
                end else begin
                    if (r_miss_cnt != CNT_MAX)
                        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                end
                r_rise <= r_hist_ok &  r_s_q & ~r_s_q_d;
                r_fall <= r_hist_ok & ~r_s_q &  r_s_q_d;
            end
        end
    end

    assign s_q       = r_s_q;
    assign match_cnt = r_match_cnt;
    assign miss_cnt  = r_miss_cnt;
    assign rise      = r_rise;
    assign fall      = r_fall;

endmodule

// File: tb/tb_eq.sv
// -----------------------------------------------------------------------------
// tb_eq
// Directed, table-driven bench for eq.
// -----------------------------------------------------------------------------
module tb_eq;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       x;
    logic       y;
    logic       s;
    logic       s_q;
    logic [7:0] match_cnt;
    logic [7:0] miss_cnt;
    logic       rise;
    logic       fall;

    int n_pass;
    int n_total;

    eq #(.CNT_W(8)) dut (
        .s         (s),
        .x         (x),
        .y         (y),
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .s_q       (s_q),
        .match_cnt (match_cnt),
        .miss_cnt  (miss_cnt),
        .rise      (rise),
        .fall      (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic x;
        logic y;
        logic s;
        logic s1;
        logic s2;
    } tt_vec_t;

    typedef struct {
        logic y;
        logic sq;
        logic rise;
        logic fall;
    } edge_vec_t;

    tt_vec_t   tt[4];
    edge_vec_t ev[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and released on falling edges, so the next rising edge
    // is the first one after reset.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, " s_q"},       32'(s_q),       32'd0);
        chk({tag, " match_cnt"}, 32'(match_cnt), 32'd0);
        chk({tag, " miss_cnt"},  32'(miss_cnt),  32'd0);
        chk({tag, " rise"},      32'(rise),      32'd0);
        chk({tag, " fall"},      32'(fall),      32'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        tt[0] = '{x: 1'b0, y: 1'b0, s: 1'b1, s1: 1'b0, s2: 1'b1};
        tt[1] = '{x: 1'b0, y: 1'b1, s: 1'b0, s1: 1'b0, s2: 1'b0};
        tt[2] = '{x: 1'b1, y: 1'b0, s: 1'b0, s1: 1'b0, s2: 1'b0};
        tt[3] = '{x: 1'b1, y: 1'b1, s: 1'b1, s1: 1'b1, s2: 1'b0};

        // x = 0, y toggles every two edges; s_q follows ~y, pulses lag s_q by one cycle
        ev[0] = '{y: 1'b0, sq: 1'b1, rise: 1'b0, fall: 1'b0};
        ev[1] = '{y: 1'b0, sq: 1'b1, rise: 1'b0, fall: 1'b0};
        ev[2] = '{y: 1'b1, sq: 1'b0, rise: 1'b0, fall: 1'b0};
        ev[3] = '{y: 1'b1, sq: 1'b0, rise: 1'b0, fall: 1'b1};
        ev[4] = '{y: 1'b0, sq: 1'b1, rise: 1'b0, fall: 1'b0};
        ev[5] = '{y: 1'b0, sq: 1'b1, rise: 1'b1, fall: 1'b0};
        ev[6] = '{y: 1'b1, sq: 1'b0, rise: 1'b0, fall: 1'b0};
        ev[7] = '{y: 1'b1, sq: 1'b0, rise: 1'b0, fall: 1'b1};
        ev[8] = '{y: 1'b0, sq: 1'b1, rise: 1'b0, fall: 1'b0};
        ev[9] = '{y: 1'b0, sq: 1'b1, rise: 1'b1, fall: 1'b0};

        rst_n = 1'b1;
        clr   = 1'b0;
        x     = 1'b0;
        y     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs_zero("reset");

        // combinational truth table, held in reset, 50-unit spacing
        for (int i = 0; i < 4; i++) begin
            x = tt[i].x;
            y = tt[i].y;
            #1;
            chk($sformatf("tt%0d s", i),  32'(s),       32'(tt[i].s));
            chk($sformatf("tt%0d s1", i), 32'(dut.s1),  32'(tt[i].s1));
            chk($sformatf("tt%0d s2", i), 32'(dut.s2),  32'(tt[i].s2));
            #49;
        end
        chk_regs_zero("reset hold");

        // pipeline: x = y = 1 for three edges after reset
        x = 1'b1;
        y = 1'b1;
        apply_reset();
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk($sformatf("pipe e%0d s_q", n),  32'(s_q),  32'd1);
            chk($sformatf("pipe e%0d rise", n), 32'(rise), 32'd0);
            chk($sformatf("pipe e%0d fall", n), 32'(fall), 32'd0);
        end
        chk("pipe match_cnt", 32'(match_cnt), 32'd2);
        chk("pipe miss_cnt",  32'(miss_cnt),  32'd1);

        // edge pulses
        x = 1'b0;
        y = ev[0].y;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            y = ev[i].y;
            tick();
            chk($sformatf("edge e%0d s_q", i + 1),  32'(s_q),  32'(ev[i].sq));
            chk($sformatf("edge e%0d rise", i + 1), 32'(rise), 32'(ev[i].rise));
            chk($sformatf("edge e%0d fall", i + 1), 32'(fall), 32'(ev[i].fall));
        end

        // saturation: s = 0 for 300 edges; miss_cnt after edge n is min(n, 255)
        x = 1'b0;
        y = 1'b1;
        apply_reset();
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 254) chk("sat miss e254", 32'(miss_cnt), 32'd254);
            if (n == 255) chk("sat miss e255", 32'(miss_cnt), 32'd255);
        end
        chk("sat miss e300",  32'(miss_cnt),  32'd255);
        chk("sat match e300", 32'(match_cnt), 32'd0);
        chk("sat s_q",        32'(s_q),       32'd0);

        // clr priority: match_cnt = 10 after edge 11 with s_q = 1
        x = 1'b1;
        y = 1'b1;
        apply_reset();
        repeat (11) tick();
        chk("clr pre match", 32'(match_cnt), 32'd10);
        chk("clr pre s_q",   32'(s_q),       32'd1);
        clr = 1'b1;
        tick();
        chk("clr match", 32'(match_cnt), 32'd0);
        chk("clr miss",  32'(miss_cnt),  32'd0);
        chk("clr s_q",   32'(s_q),       32'd1);
        clr = 1'b0;
        tick();
        chk("clr post match", 32'(match_cnt), 32'd1);

        // asynchronous reset mid-operation, between edges
        apply_reset();
        repeat (6) tick();
        chk("arst pre match", 32'(match_cnt), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs_zero("arst");
        x = 1'b0;
        y = 1'b1;
        #1;
        chk("arst s 01", 32'(s), 32'd0);
        x = 1'b0;
        y = 1'b0;
        #1;
        chk("arst s 00", 32'(s), 32'd1);
        chk("arst s2",   32'(dut.s2), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("arst reload s_q", 32'(s_q),  32'd1);
        chk("arst reload rise", 32'(rise), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
